// File: rtl/reducer_arbiter_if.sv
// Bus bundle between the EC arithmetic requesters, the shared reducer and the arbiter.
interface reducer_arbiter_if #(
  parameter int unsigned DW_IN  = 510,
  parameter int unsigned DW_OUT = 255
);
  // Requester request channels
  logic              i_req0_valid;
  logic [DW_IN-1:0]  i_req0_data;
  logic              o_req0_ready;
  logic              i_req1_valid;
  logic [DW_IN-1:0]  i_req1_data;
  logic              o_req1_ready;

  // Requester response channels
  logic              o_rsp0_valid;
  logic [DW_OUT-1:0] o_rsp0_data;
  logic              i_rsp0_ready;
  logic              o_rsp1_valid;
  logic [DW_OUT-1:0] o_rsp1_data;
  logic              i_rsp1_ready;

  // Reducer channels
  logic              o_red_in_valid;
  logic [DW_IN-1:0]  o_red_in_data;
  logic              i_red_in_ready;
  logic              i_red_out_valid;
  logic [DW_OUT-1:0] i_red_out_data;
  logic              o_red_out_ready;

  // Status
  logic              o_busy;
  logic              o_err_orphan;

  // Arbiter side
  modport slave (
    input  i_req0_valid, i_req0_data, i_req1_valid, i_req1_data,
    input  i_rsp0_ready, i_rsp1_ready,
    input  i_red_in_ready, i_red_out_valid, i_red_out_data,
    output o_req0_ready, o_req1_ready,
    output o_rsp0_valid, o_rsp0_data, o_rsp1_valid, o_rsp1_data,
    output o_red_in_valid, o_red_in_data, o_red_out_ready,
    output o_busy, o_err_orphan
  );

  // Environment side (requesters + reducer)
  modport master (
    output i_req0_valid, i_req0_data, i_req1_valid, i_req1_data,
    output i_rsp0_ready, i_rsp1_ready,
    output i_red_in_ready, i_red_out_valid, i_red_out_data,
    input  o_req0_ready, o_req1_ready,
    input  o_rsp0_valid, o_rsp0_data, o_rsp1_valid, o_rsp1_data,
    input  o_red_in_valid, o_red_in_data, o_red_out_ready,
    input  o_busy, o_err_orphan
  );
endinterface

// File: rtl/reducer_arbiter.sv
// Round-robin sharing of the modular reducer between the point-add (0) and
// point-double (1) units, with in-order result routing via a tag FIFO.
module reducer_arbiter #(
  parameter int unsigned DW_IN     = 510,
  parameter int unsigned DW_OUT    = 255,
  parameter int unsigned TAG_DEPTH = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  reducer_arbiter_if.slave   bus
);

  localparam int unsigned PTR_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic {
    ST_OPEN   = 1'b0,
    ST_LOCKED = 1'b1
  } lock_state_e;

  lock_state_e          state_q, state_d;
  logic                 grant_r, grant_d;
  logic                 prio_r;
  logic [TAG_DEPTH-1:0] tag_mem_r;
  logic [PTR_W-1:0]     wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0]     count_r;
  logic                 err_orphan_r;

  logic                 grant_c;
  logic                 granted_valid_c;
  logic [DW_IN-1:0]     granted_data_c;
  logic [DW_OUT-1:0]    result_c;
  logic                 fifo_full_c, fifo_empty_c;
  logic                 head_tag_c;
  logic                 red_in_valid_c, red_in_fire_c;
  logic                 red_out_ready_c, red_out_fire_c;
  logic                 head_rsp_ready_c;

  assign fifo_full_c  = (count_r == CNT_W'(TAG_DEPTH));
  assign fifo_empty_c = (count_r == CNT_W'(0));
  assign head_tag_c   = tag_mem_r[rd_ptr_r];

  // Grant select: held while locked, otherwise sole requester or priority holder
  always_comb begin
    grant_c = prio_r;
    if (state_q == ST_LOCKED) begin
      grant_c = grant_r;
    end else if (bus.i_req0_valid && !bus.i_req1_valid) begin
      grant_c = 1'b0;
    end else if (bus.i_req1_valid && !bus.i_req0_valid) begin
      grant_c = 1'b1;
    end
  end

  // Request path toward the reducer; a full tag FIFO stalls everything
  always_comb begin
    granted_valid_c = grant_c ? bus.i_req1_valid : bus.i_req0_valid;
    granted_data_c  = grant_c ? bus.i_req1_data  : bus.i_req0_data;
    red_in_valid_c  = granted_valid_c && !fifo_full_c;
    red_in_fire_c   = red_in_valid_c && bus.i_red_in_ready;
  end

  assign bus.o_red_in_valid = red_in_valid_c;
  assign bus.o_red_in_data  = granted_data_c;
  assign bus.o_req0_ready   = !grant_c && bus.i_red_in_ready && !fifo_full_c;
  assign bus.o_req1_ready   =  grant_c && bus.i_red_in_ready && !fifo_full_c;

  // Response routing by the oldest outstanding tag
  always_comb begin
    result_c         = bus.i_red_out_data;
    head_rsp_ready_c = head_tag_c ? bus.i_rsp1_ready : bus.i_rsp0_ready;
    red_out_ready_c  = !fifo_empty_c && head_rsp_ready_c;
    red_out_fire_c   = bus.i_red_out_valid && red_out_ready_c;
  end

  assign bus.o_rsp0_valid    = bus.i_red_out_valid && !fifo_empty_c && !head_tag_c;
  assign bus.o_rsp1_valid    = bus.i_red_out_valid && !fifo_empty_c &&  head_tag_c;
  assign bus.o_rsp0_data     = result_c;
  assign bus.o_rsp1_data     = result_c;
  assign bus.o_red_out_ready = red_out_ready_c;

  assign bus.o_busy       = (count_r != CNT_W'(0)) || bus.i_req0_valid || bus.i_req1_valid;
  assign bus.o_err_orphan = err_orphan_r;

  // Lock FSM next state: a stalled reducer request pins the grant until it fires
  always_comb begin
    state_d = state_q;
    grant_d = grant_r;
    unique case (state_q)
      ST_OPEN: begin
        if (red_in_valid_c && !bus.i_red_in_ready) begin
          state_d = ST_LOCKED;
          grant_d = grant_c;
        end
      end
      ST_LOCKED: begin
        if (red_in_fire_c) begin
          state_d = ST_OPEN;
        end
      end
      default: begin
        state_d = ST_OPEN;
      end
    endcase
  end

  // Lock FSM state and held grant
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= ST_OPEN;
      grant_r <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_r <= grant_d;
    end
  end

  // Round-robin priority: the requester that just fired yields to the other
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      prio_r <= 1'b0;
    end else if (red_in_fire_c) begin
      prio_r <= ~grant_c;
    end
  end

  // Tag FIFO: push requester id on reducer-input fire, pop on result fire
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      tag_mem_r <= '0;
      wr_ptr_r  <= '0;
      rd_ptr_r  <= '0;
      count_r   <= '0;
    end else begin
      if (red_in_fire_c) begin
        tag_mem_r[wr_ptr_r] <= grant_c;
        wr_ptr_r            <= wr_ptr_r + PTR_W'(1);
      end
      if (red_out_fire_c) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      unique case ({red_in_fire_c, red_out_fire_c})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Sticky flag for a reducer result with no outstanding tag
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      err_orphan_r <= 1'b0;
    end else if (bus.i_red_out_valid && fifo_empty_c) begin
      err_orphan_r <= 1'b1;
    end
  end

endmodule
